// File: rtl/vga_pkg.sv
// vga_pkg: shared 800x600 timing defaults, colour constants and FSM state
// definitions for the VGA drawing canvas.
package vga_pkg;
    localparam int VGA_H_SYNC   = 128;
    localparam int VGA_H_BACK   = 88;
    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_H_FRONT  = 40;
    localparam int VGA_V_SYNC   = 4;
    localparam int VGA_V_BACK   = 23;
    localparam int VGA_V_ACTIVE = 600;
    localparam int VGA_V_FRONT  = 1;
    localparam int POS_W  = 11;
    localparam int DIFF_W = 12;

    typedef logic [11:0] rgb_t;

    localparam rgb_t COL_CURSOR = 12'hF00;
    localparam rgb_t COL_DRAW   = 12'h00F;
    localparam rgb_t COL_ERASE  = 12'h0F0;
    localparam rgb_t COL_INK    = 12'hF0F;
    localparam rgb_t COL_PAPER  = 12'hFFF;
    localparam rgb_t COL_BG     = 12'h33F;
    localparam rgb_t COL_BLANK  = 12'h000;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters, raw syncs, active-area flag and
// active-area pixel position.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BACK   = VGA_H_BACK,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FRONT  = VGA_H_FRONT,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BACK   = VGA_V_BACK,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FRONT  = VGA_V_FRONT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             hs_o,
    output logic             vs_o,
    output logic             active_o,
    output logic             fp_start_o,
    output logic [POS_W-1:0] hpos_o,
    output logic [POS_W-1:0] vpos_o
);
    localparam logic [POS_W-1:0] H_SYN  = POS_W'(H_SYNC);
    localparam logic [POS_W-1:0] H_BEG  = POS_W'(H_SYNC + H_BACK);
    localparam logic [POS_W-1:0] H_END  = POS_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
    localparam logic [POS_W-1:0] V_SYN  = POS_W'(V_SYNC);
    localparam logic [POS_W-1:0] V_BEG  = POS_W'(V_SYNC + V_BACK);
    localparam logic [POS_W-1:0] V_END  = POS_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);

    logic [POS_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + POS_W'(1);
        v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + POS_W'(1);
    end

    assign hs_o       = h_cnt_q >= H_SYN;
    assign vs_o       = v_cnt_q >= V_SYN;
    assign active_o   = h_cnt_q >= H_BEG && h_cnt_q < H_END && v_cnt_q >= V_BEG && v_cnt_q < V_END;
    assign fp_start_o = h_cnt_q == '0 && v_cnt_q == V_END;
    assign hpos_o     = h_cnt_q - H_BEG;
    assign vpos_o     = v_cnt_q - V_BEG;
endmodule

// File: rtl/vga_canvas.sv
// vga_canvas: VGA timing plus a GRID x GRID one-bit drawing canvas with cursor
// draw/erase, row-by-row clear and a frame-stable snapshot for the classifier.
module vga_canvas
    import vga_pkg::*;
#(
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int GRID       = 32,
    parameter int CELL_SHIFT = 4,
    parameter int CURSOR_R   = 8
) (
    input  logic                 clkVga,
    input  logic                 iRstN,
    input  logic [POS_W-1:0]     iCurX,
    input  logic [POS_W-1:0]     iCurY,
    input  logic                 iDraw,
    input  logic                 iErase,
    input  logic                 iClear,
    output logic [3:0]           oRed,
    output logic [3:0]           oGreen,
    output logic [3:0]           oBlue,
    output logic                 oHs,
    output logic                 oVs,
    output logic                 oClearBusy,
    output logic [GRID*GRID-1:0] oImage,
    output logic                 oImageStrobe
);
    localparam int CW = $clog2(GRID);
    localparam int N  = GRID * GRID;
    localparam logic [POS_W-1:0]        CANVAS_PX = POS_W'(GRID << CELL_SHIFT);
    localparam logic [CW-1:0]           ROW_LAST  = CW'(GRID - 1);
    localparam logic signed [DIFF_W-1:0] BOX_R    = DIFF_W'(CURSOR_R);

    logic                      hs_raw, vs_raw, active, fp_start;
    logic [POS_W-1:0]          hpos, vpos;
    state_t                    state_q, state_d;
    logic [CW-1:0]             row_q, row_d;
    logic [N-1:0]              canvas_q, canvas_d, image_q;
    rgb_t                      rgb_q, rgb_d;
    logic                      hs_q, vs_q, strobe_q;
    logic                      cur_ok, in_canvas, in_box;
    logic [2*CW-1:0]           cur_idx, px_idx;
    logic signed [DIFF_W-1:0]  dx, dy;

    vga_timing #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
    ) u_timing (
        .clk_i(clkVga), .rst_ni(iRstN), .hs_o(hs_raw), .vs_o(vs_raw), .active_o(active),
        .fp_start_o(fp_start), .hpos_o(hpos), .vpos_o(vpos)
    );

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = (state_q == ST_IDLE) ? (iClear ? ST_CLEAR : ST_IDLE)
                                       : ((row_q == ROW_LAST) ? ST_IDLE : ST_CLEAR);
        row_d   = (state_q == ST_IDLE) ? '0 : row_q + CW'(1);
    end

    assign oClearBusy = state_q == ST_CLEAR;

    assign cur_ok  = iCurX < CANVAS_PX && iCurY < CANVAS_PX;
    assign cur_idx = {iCurY[CELL_SHIFT +: CW], iCurX[CELL_SHIFT +: CW]};

    always_comb begin
        canvas_d = canvas_q;
        if (state_q == ST_CLEAR)
            canvas_d[{row_q, {CW{1'b0}}} +: GRID] = '0;
        else if (cur_ok && (iDraw || iErase))
            canvas_d[cur_idx] = !iErase;
    end

    // Zero-extended 12-bit differences so a cursor near 0 clips instead of wrapping.
    assign dx        = DIFF_W'(hpos) - DIFF_W'(iCurX);
    assign dy        = DIFF_W'(vpos) - DIFF_W'(iCurY);
    assign in_box    = dx >= -BOX_R && dx <= BOX_R && dy >= -BOX_R && dy <= BOX_R;
    assign in_canvas = hpos < CANVAS_PX && vpos < CANVAS_PX;
    assign px_idx    = {vpos[CELL_SHIFT +: CW], hpos[CELL_SHIFT +: CW]};

    always_comb begin
        rgb_d = !active   ? COL_BLANK
              : in_box    ? (iErase ? COL_ERASE : iDraw ? COL_DRAW : COL_CURSOR)
              : in_canvas ? (canvas_q[px_idx] ? COL_INK : COL_PAPER)
              : COL_BG;
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            canvas_q <= '0;
            image_q  <= '0;
            strobe_q <= 1'b0;
            rgb_q    <= COL_BLANK;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            canvas_q <= canvas_d;
            image_q  <= fp_start ? canvas_q : image_q;
            strobe_q <= fp_start;
            rgb_q    <= rgb_d;
            hs_q     <= hs_raw;
            vs_q     <= vs_raw;
        end
    end

    assign {oRed, oGreen, oBlue} = rgb_q;
    assign oHs          = hs_q;
    assign oVs          = vs_q;
    assign oImage       = image_q;
    assign oImageStrobe = strobe_q;
endmodule
